// File: rtl/fifo_rd_ctrl_if.sv
// Read-side FIFO handshake bundle: consumer request, write-domain Gray
// pointer in, and the read controller's address, pointer and status out.
interface fifo_rd_ctrl_if #(
  parameter int unsigned ADDR_W = 3
);
  logic              r_en;
  logic [ADDR_W:0]   wptr_gray;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   rptr_gray;
  logic              r_empty;
  logic              r_almost_empty;
  logic [ADDR_W:0]   r_count;
  logic              r_underflow;

  // Consumer / write-pointer source side
  modport master (
    output r_en, wptr_gray,
    input  r_addr, rptr_gray, r_empty, r_almost_empty, r_count, r_underflow
  );

  // Read controller side
  modport slave (
    input  r_en, wptr_gray,
    output r_addr, rptr_gray, r_empty, r_almost_empty, r_count, r_underflow
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller for the asynchronous FIFO: synchronises the write
// Gray pointer, advances binary/Gray read pointers and registers the empty,
// almost-empty, fill-count and underflow status.
module fifo_rd_ctrl #(
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_THRESH   = 1
) (
  input logic           r_clk,
  input logic           r_rst,
  fifo_rd_ctrl_if.slave bus
);
  localparam int unsigned   PW       = ADDR_W + 1;
  localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wsync;
  logic [PW-1:0] wsync_bin;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] count;
  logic [PW-1:0] count_next;
  logic          empty;
  logic          almost_empty;
  logic          underflow;
  logic          rd_ok;

  // Write-pointer synchroniser chain; nothing else samples wptr_gray
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.wptr_gray;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wsync = sync_q[SYNC_STAGES-1];

  // Gray-to-binary of the synchronised write pointer: bit i is the XOR of bits i and above
  always_comb begin
    wsync_bin = '0;
    for (int unsigned i = 0; i < PW; i++) wsync_bin[i] = ^(wsync >> i);
  end

  // Next read pointer and fill level, folding this cycle's read into the flags
  always_comb begin
    rd_ok      = bus.r_en & ~empty;
    rbin_next  = rbin + {{ADDR_W{1'b0}}, rd_ok};
    rgray_next = rbin_next ^ (rbin_next >> 1);
    count_next = wsync_bin - rbin_next;
  end

  // Pointer and status registers, all updated together on the same edge
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      rbin         <= '0;
      rgray        <= '0;
      count        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      underflow    <= 1'b0;
    end else begin
      rbin         <= rbin_next;
      rgray        <= rgray_next;
      count        <= count_next;
      empty        <= (rgray_next == wsync);
      almost_empty <= (count_next <= AE_LIMIT);
      underflow    <= bus.r_en & empty;
    end
  end

  assign bus.r_addr         = rbin[ADDR_W-1:0];
  assign bus.rptr_gray      = rgray;
  assign bus.r_empty        = empty;
  assign bus.r_almost_empty = almost_empty;
  assign bus.r_count        = count;
  assign bus.r_underflow    = underflow;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl (ADDR_W=3, SYNC_STAGES=2, AE_THRESH=1):
// directed vector table, hand-written corner sequences and a randomized run
// against a total-count reference model.
module tb_fifo_rd_ctrl;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned SYNC   = 2;
  localparam int          AE     = 1;

  typedef struct {
    logic en;
    int   wbin;
    logic empty;
    int   count;
    logic ae;
    logic uf;
    int   rbin;
  } vec_t;

  logic r_clk;
  logic r_rst;
  int   checks;
  int   errors;

  fifo_rd_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  fifo_rd_ctrl #(
    .ADDR_W     (ADDR_W),
    .SYNC_STAGES(SYNC),
    .AE_THRESH  (AE)
  ) dut (
    .r_clk(r_clk),
    .r_rst(r_rst),
    .bus  (bus)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  function automatic logic [3:0] b2g(input int b);
    logic [3:0] x;
    x = b[3:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_empty, input int e_count,
                           input logic e_ae, input logic e_uf, input int e_rbin);
    chk({tag, ".r_empty"},        32'(bus.r_empty),        32'(e_empty));
    chk({tag, ".r_count"},        32'(bus.r_count),        32'(e_count));
    chk({tag, ".r_almost_empty"}, 32'(bus.r_almost_empty), 32'(e_ae));
    chk({tag, ".r_underflow"},    32'(bus.r_underflow),    32'(e_uf));
    chk({tag, ".r_addr"},         32'(bus.r_addr),         32'(e_rbin % 8));
    chk({tag, ".rptr_gray"},      32'(bus.rptr_gray),      32'(b2g(e_rbin)));
  endtask

  task automatic do_reset();
    @(negedge r_clk);
    bus.r_en      = 1'b0;
    bus.wptr_gray = '0;
    r_rst         = 1'b0;
    repeat (2) @(negedge r_clk);
    r_rst = 1'b1;
  endtask

  vec_t tbl [17];

  initial begin
    logic [3:0] prev;
    bit         seen;
    int         rtot, wtot, wvis, mcount;
    logic       mempty, men, muf;
    int         dq [$];

    checks = 0;
    errors = 0;

    // expected outputs after the edge that samples the row's inputs
    tbl[0]  = '{1'b0, 1, 1'b1, 0, 1'b1, 1'b0, 0};
    tbl[1]  = '{1'b0, 1, 1'b1, 0, 1'b1, 1'b0, 0};
    tbl[2]  = '{1'b0, 1, 1'b0, 1, 1'b1, 1'b0, 0};
    tbl[3]  = '{1'b1, 1, 1'b1, 0, 1'b1, 1'b0, 1};
    tbl[4]  = '{1'b1, 1, 1'b1, 0, 1'b1, 1'b1, 1};
    tbl[5]  = '{1'b0, 9, 1'b1, 0, 1'b1, 1'b0, 1};
    tbl[6]  = '{1'b0, 9, 1'b1, 0, 1'b1, 1'b0, 1};
    tbl[7]  = '{1'b0, 9, 1'b0, 8, 1'b0, 1'b0, 1};
    tbl[8]  = '{1'b1, 9, 1'b0, 7, 1'b0, 1'b0, 2};
    tbl[9]  = '{1'b1, 9, 1'b0, 6, 1'b0, 1'b0, 3};
    tbl[10] = '{1'b1, 9, 1'b0, 5, 1'b0, 1'b0, 4};
    tbl[11] = '{1'b1, 9, 1'b0, 4, 1'b0, 1'b0, 5};
    tbl[12] = '{1'b1, 9, 1'b0, 3, 1'b0, 1'b0, 6};
    tbl[13] = '{1'b1, 9, 1'b0, 2, 1'b0, 1'b0, 7};
    tbl[14] = '{1'b1, 9, 1'b0, 1, 1'b1, 1'b0, 8};
    tbl[15] = '{1'b1, 9, 1'b1, 0, 1'b1, 1'b0, 9};
    tbl[16] = '{1'b1, 9, 1'b1, 0, 1'b1, 1'b1, 9};

    // reset held with random inputs
    r_rst         = 1'b0;
    bus.r_en      = 1'b0;
    bus.wptr_gray = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge r_clk);
      bus.r_en      = 1'($urandom_range(0, 1));
      bus.wptr_gray = 4'($urandom_range(0, 15));
      @(posedge r_clk);
      #1 check_all("reset", 1'b1, 0, 1'b1, 1'b0, 0);
    end
    @(negedge r_clk);
    bus.r_en      = 1'b0;
    bus.wptr_gray = '0;
    r_rst         = 1'b1;

    // latency, single read, underflow and full drain
    for (int i = 0; i < 17; i++) begin
      @(negedge r_clk);
      bus.r_en      = tbl[i].en;
      bus.wptr_gray = b2g(tbl[i].wbin);
      @(posedge r_clk);
      #1 check_all($sformatf("vec%0d", i), tbl[i].empty, tbl[i].count,
                   tbl[i].ae, tbl[i].uf, tbl[i].rbin);
    end

    // two-cycle underflow pulse from an idle empty state
    @(negedge r_clk); bus.r_en = 1'b0;
    @(posedge r_clk); #1 chk("uf_idle", 32'(bus.r_underflow), 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge r_clk); bus.r_en = 1'b1;
      @(posedge r_clk); #1 check_all($sformatf("uf%0d", i), 1'b1, 0, 1'b1, 1'b1, 9);
    end
    @(negedge r_clk); bus.r_en = 1'b0;
    @(posedge r_clk); #1 check_all("uf_end", 1'b1, 0, 1'b1, 1'b0, 9);

    // asynchronous reset in the middle of a burst at count 5
    do_reset();
    @(negedge r_clk); bus.wptr_gray = b2g(7);
    repeat (3) @(posedge r_clk);
    #1 chk("mid.count_sync", 32'(bus.r_count), 7);
    @(negedge r_clk); bus.r_en = 1'b1;
    repeat (2) @(posedge r_clk);
    #1 check_all("mid.burst", 1'b0, 5, 1'b0, 1'b0, 2);
    @(negedge r_clk);
    #2 r_rst = 1'b0;
    #1 check_all("mid.async", 1'b1, 0, 1'b1, 1'b0, 0);
    bus.r_en      = 1'b0;
    bus.wptr_gray = '0;
    @(negedge r_clk); r_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge r_clk);
      #1 check_all("mid.after", 1'b1, 0, 1'b1, 1'b0, 0);
    end

    // 20 write/read pairs across the pointer wrap
    for (int i = 0; i < 20; i++) begin
      @(negedge r_clk);
      bus.r_en      = 1'b0;
      bus.wptr_gray = b2g(i + 1);
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
        @(posedge r_clk);
        #1 if (!bus.r_empty) seen = 1'b1;
      end
      chk($sformatf("wrap%0d.visible", i), 32'(seen), 1);
      chk($sformatf("wrap%0d.r_addr", i), 32'(bus.r_addr), 32'(i % 8));
      prev = bus.rptr_gray;
      @(negedge r_clk); bus.r_en = 1'b1;
      @(posedge r_clk);
      #1;
      chk($sformatf("wrap%0d.onebit", i), 32'($countones(prev ^ bus.rptr_gray)), 1);
      chk($sformatf("wrap%0d.r_empty", i), 32'(bus.r_empty), 1);
      if (i == 15) begin
        chk("wrap.gray_from", 32'(prev), 32'(4'b1000));
        chk("wrap.gray_to",   32'(bus.rptr_gray), 32'(4'b0000));
      end
    end
    @(negedge r_clk); bus.r_en = 1'b0;
    @(posedge r_clk); #1 chk("wrap.final_gray", 32'(bus.rptr_gray), 32'(b2g(20)));

    // randomized traffic against an unbounded-total reference model
    do_reset();
    rtot   = 0;
    wtot   = 0;
    mempty = 1'b1;
    mcount = 0;
    dq     = {};
    for (int i = 0; i < SYNC; i++) dq.push_back(0);
    for (int i = 0; i < 600; i++) begin
      @(negedge r_clk);
      men = 1'($urandom_range(0, 1));
      if ((wtot - rtot) < 8 && $urandom_range(0, 2) != 0) wtot++;
      bus.r_en      = men;
      bus.wptr_gray = b2g(wtot);
      @(posedge r_clk);
      wvis = dq[0];
      muf  = men && mempty;
      if (men && !mempty) rtot++;
      mcount = wvis - rtot;
      mempty = (mcount == 0);
      dq.push_back(wtot);
      void'(dq.pop_front());
      #1 check_all($sformatf("rnd%0d", i), mempty, mcount, (mcount <= AE), muf, rtot);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Parametrised read-side controller for the asynchronous FIFO, owned by the read clock domain. It synchronises the write-domain Gray pointer internally and keeps the binary and Gray read pointers. It produces registered empty and almost-empty flags, a fill count and an underflow strobe. It sits between the dual-port FIFO RAM read port and the read-domain consumer, and exports its Gray pointer to the write-side controller.

## Interface
- ADDR_W, 3, RAM address width; depth = 2^ADDR_W; pointers are ADDR_W+1 bits
- SYNC_STAGES, 2, flops in the wptr_gray synchroniser chain (legal ≥2)
- AE_THRESH, 1, almost-empty asserts when fill count ≤ AE_THRESH (legal 0..2^ADDR_W-1)

Ports:
- r_clk  in  1  read-domain clock
- r_rst  in  1  reset, asynchronous, active-low
- r_en  in  1  read request; honoured only when r_empty=0
- wptr_gray  in  ADDR_W+1  write pointer, Gray coded, from write domain (asynchronous)
- r_addr  out  ADDR_W  RAM read address = low ADDR_W bits of binary read pointer
- rptr_gray  out  ADDR_W+1  registered Gray read pointer to write domain
- r_empty  out  1  registered; FIFO holds no readable entry
- r_almost_empty  out  1  registered; r_count ≤ AE_THRESH
- r_count  out  ADDR_W+1  registered fill level seen from read side, 0..2^ADDR_W
- r_underflow  out  1  one-cycle pulse; r_en sampled while r_empty=1

## Operation
- Synchroniser: wptr_gray passes through SYNC_STAGES flops, giving wsync. No other logic touches wptr_gray.
- rd_ok = r_en & ~r_empty.
- rbin_next = rbin + rd_ok, modulo 2^(ADDR_W+1).
- rgray_next = rbin_next ^ (rbin_next >> 1).
- Each r_clk edge:
  - rbin ← rbin_next
  - rptr_gray ← rgray_next
  - r_empty ← (rgray_next == wsync)
  - r_count ← gray2bin(wsync) − rbin_next, modulo 2^(ADDR_W+1)
  - r_almost_empty ← (that count ≤ AE_THRESH)
  - r_underflow ← r_en & r_empty
- r_addr = rbin[ADDR_W-1:0]. The RAM presents data for r_addr combinationally. The consumer takes data in the cycle r_en is high with r_empty low.
- Underflow: the pointers, count and flags are unchanged. The only effect is the r_underflow pulse.
- Wrap-around:
  - The binary pointer rolls from 2^(ADDR_W+1)−1 to 0.
  - The Gray pointer rolls, e.g. 4'b1000 → 4'b0000 for ADDR_W=3.
  - Exactly one Gray bit changes per increment.
  - Flags and count stay correct across the wrap.
- Simultaneous read and wsync change: both are folded into the same-edge computation. Empty uses the post-read pointer against the current wsync.
- Reset (any time, including mid-burst, asynchronous assert): all registers clear.
  - rbin=0, rptr_gray=0, r_addr=0, synchroniser flops=0
  - r_empty=1, r_almost_empty=1, r_count=0, r_underflow=0
- Deassertion is treated as synchronous to r_clk by the reset synchroniser upstream.

## Timing
- Read-pointer update: 1 edge. A read at edge n makes r_addr and rptr_gray advance after edge n.
- Empty after the last read: r_empty rises at the same edge that consumes the final entry. There is no extra read window.
- Write visibility: wptr_gray changing before edge k clears r_empty and updates r_count after edge k+SYNC_STAGES. That is SYNC_STAGES+1 edges of latency, so 3 for the default.
- r_empty, r_count and r_almost_empty update together. They are never mutually inconsistent in any cycle.
- r_underflow is high for exactly the cycle after the offending r_en sample.
- Throughput: one read per r_clk cycle while not empty.

## Test plan
- Reset: hold r_rst=0 with random r_en and wptr_gray. Require r_empty=1, r_almost_empty=1, r_count=0, r_addr=0, rptr_gray=0, r_underflow=0.
- Latency: wptr_gray 0→1 with ADDR_W=3, SYNC_STAGES=2. Require r_empty=0, r_count=1 exactly 3 edges later. With r_en=1, r_addr goes 0→1, rptr_gray=4'b0001, and r_empty=1 at that same edge.
- Full drain with almost-empty:
  - Set wptr_gray=bin2gray(8).
  - Require r_count=8 after sync; r_almost_empty=0.
  - Read 8 with r_en held high: r_count steps 7,6,…,0.
  - r_almost_empty rises when r_count=1; r_empty rises with r_count=0.
- Wrap:
  - Run 20 write/read pairs.
  - rptr_gray passes 4'b1000→4'b0000.
  - r_addr sequence is 0..7,0..7,0..3.
  - Exactly one rptr_gray bit toggles per read.
- Underflow: with r_empty=1, pulse r_en for 2 cycles. Require r_underflow high for 2 cycles, each lagging by one. Pointers are unchanged.
- Reset mid-read:
  - Assert r_rst low during a burst with r_count=5.
  - Outputs clear immediately, without waiting for r_clk.
  - After release with wptr_gray=0, r_empty stays 1.
